// File: rtl/aes_inv_shift_rows_stage.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_shift_rows_stage
// Description : AES InvShiftRows pipeline stage with valid/ready handshake.
//               Define AES_INV_SR_SKID_EN for a 2-entry skid buffer with a
//               registered in_ready; default is a single output register.
// Revision    : 1.0
// ============================================================================
module aes_inv_shift_rows_stage #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       occupancy
);

    localparam logic [1:0] c_OCC_EMPTY = 2'd0;
    localparam logic [1:0] c_OCC_ONE   = 2'd1;
    localparam logic [1:0] c_OCC_TWO   = 2'd2;

    logic [127:0]     w_sr_data;
    logic             w_push;
    logic             w_pop;

    logic [1:0]       occ_q;
    logic [127:0]     head_data_q;
    logic [TAG_W-1:0] head_tag_q;
    logic [127:0]     skid_data_q;
    logic [TAG_W-1:0] skid_tag_q;

    // Byte (r,c) of the result is byte (r,(c-r) mod 4) of the input.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign w_sr_data[127-8*(4*c+r) -: 8] =
                in_data[127-8*(4*((c-r+4)%4)+r) -: 8];
        end
    end

`ifdef AES_INV_SR_SKID_EN
    assign in_ready = ~rst & ~flush & (occ_q != c_OCC_TWO);
`else
    assign in_ready = ~rst & ~flush & ((occ_q == c_OCC_EMPTY) | out_ready);
`endif

    assign out_valid = (occ_q != c_OCC_EMPTY);
    assign out_data  = head_data_q;
    assign out_tag   = head_tag_q;
    assign occupancy = occ_q;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q       <= c_OCC_EMPTY;
            head_data_q <= '0;
            head_tag_q  <= '0;
            skid_data_q <= '0;
            skid_tag_q  <= '0;
        end else if (flush) begin
            occ_q <= c_OCC_EMPTY;
        end else begin
            case (occ_q)
                c_OCC_EMPTY: begin
                    if (w_push) begin
                        head_data_q <= w_sr_data;
                        head_tag_q  <= in_tag;
                        occ_q       <= c_OCC_ONE;
                    end
                end
                c_OCC_ONE: begin
                    if (w_push && w_pop) begin
                        head_data_q <= w_sr_data;
                        head_tag_q  <= in_tag;
                    end else if (w_push) begin
                        // Head is stalled, so the new state parks in the skid slot.
                        skid_data_q <= w_sr_data;
                        skid_tag_q  <= in_tag;
                        occ_q       <= c_OCC_TWO;
                    end else if (w_pop) begin
                        occ_q <= c_OCC_EMPTY;
                    end
                end
                default: begin
                    if (w_pop) begin
                        head_data_q <= skid_data_q;
                        head_tag_q  <= skid_tag_q;
                        occ_q       <= c_OCC_ONE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_shift_rows_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_inv_shift_rows_stage
// Description : Self-checking bench for aes_inv_shift_rows_stage against a
//               row-rotation reference model and a FIFO scoreboard.
// Revision    : 1.0
// ============================================================================
module tb_aes_inv_shift_rows_stage;

    localparam int TAG_W = 4;
`ifdef AES_INV_SR_SKID_EN
    localparam bit SKID   = 1'b1;
    localparam int MAXOCC = 2;
`else
    localparam bit SKID   = 1'b0;
    localparam int MAXOCC = 1;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    logic [1:0]       occupancy;

    aes_inv_shift_rows_stage #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int               total = 0;
    int               bad   = 0;
    int               n_out = 0;
    logic [127:0]     qd[$];
    logic [TAG_W-1:0] qt[$];
    logic             last_acc;
    logic             stall_prev = 1'b0;
    logic [127:0]     held_d;
    logic [TAG_W-1:0] held_t;

    // Reference: unpack into a 4x4 matrix, rotate row r right r times, repack.
    function automatic logic [127:0] ref_isr(input logic [127:0] s);
        logic [7:0]   m[4][4];
        logic [7:0]   t;
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = s[127-8*(4*c+r) -: 8];
        for (int r = 0; r < 4; r++) begin
            repeat (r) begin
                t = m[r][3]; m[r][3] = m[r][2]; m[r][2] = m[r][1];
                m[r][1] = m[r][0]; m[r][0] = t;
            end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = m[r][c];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, update scoreboard, step.
    task automatic tick();
        logic er, acc, del;
        #1;
        er = !rst && !flush && (SKID ? (qd.size() < 2) : (qd.size() == 0 || out_ready));
        chk("in_ready", in_ready, er);
        chk("occupancy", occupancy, qd.size());
        chk("out_valid", out_valid, qd.size() != 0);
        if (stall_prev) begin
            chk("hold_data", out_data, held_d);
            chk("hold_tag", out_tag, held_t);
        end
        acc = in_valid && in_ready;
        del = out_valid && out_ready && !rst && !flush;
        if (del && qd.size() > 0) begin
            chk("out_data", out_data, qd[0]);
            chk("out_tag", out_tag, qt[0]);
            void'(qd.pop_front());
            void'(qt.pop_front());
            n_out++;
        end
        if (acc) begin
            qd.push_back(ref_isr(in_data));
            qt.push_back(in_tag);
        end
        stall_prev = out_valid && !out_ready && !rst && !flush;
        held_d     = out_data;
        held_t     = out_tag;
        if (rst || flush) begin
            qd.delete();
            qt.delete();
        end
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k, cyc, base, sent;
        logic [127:0] bp[8];

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_tag = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset state
        chk("rst_out_data", out_data, 128'h0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        tick();
        rst = 1'b0; #1;
        chk("ready_after_rst", in_ready, 1);

        // FIPS-197 vector
        in_valid = 1'b1; in_data = 128'h7ad5fda789ef4e272bca100b3d9ff59f; in_tag = 4'd3;
        tick();
        in_valid = 1'b0; #1;
        chk("fips_valid", out_valid, 1);
        chk("fips_data", out_data, 128'h7a9f102789d5f50b2beffd9f3dca4ea7);
        chk("fips_tag", out_tag, 3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Identity pattern
        in_valid = 1'b1; in_data = 128'h000102030405060708090a0b0c0d0e0f; in_tag = 4'd5;
        tick();
        in_valid = 1'b0; #1;
        chk("ident_data", out_data, 128'h000d0a0704010e0b0805020f0c090603);
        chk("ident_tag", out_tag, 5);
        out_ready = 1'b1;
        tick();

        // Back-pressure: 8 back-to-back inputs, downstream stalled for 5 cycles
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) bp[i] = rnd128();
        k = 0; base = n_out;
        in_valid = 1'b1; in_data = bp[0]; in_tag = 4'd0;
        repeat (5) begin
            tick();
            if (last_acc) begin
                k++;
                if (k < 8) begin in_data = bp[k]; in_tag = k[TAG_W-1:0]; end
                else in_valid = 1'b0;
            end
        end
        #1;
        chk("bp_full_occ", occupancy, MAXOCC);
        chk("bp_full_ready", in_ready, 0);
        out_ready = 1'b1;
        cyc = 0;
        while ((k < 8 || qd.size() != 0) && cyc < 50) begin
            tick();
            cyc++;
            if (last_acc) begin
                k++;
                if (k < 8) begin in_data = bp[k]; in_tag = k[TAG_W-1:0]; end
                else in_valid = 1'b0;
            end
        end
        chk("bp_delivered", n_out - base, 8);

        // Flush with a same-cycle input
        out_ready = 1'b0; in_valid = 1'b1; cyc = 0;
        while (qd.size() < MAXOCC && cyc < 10) begin
            in_data = rnd128(); in_tag = 4'hA;
            tick();
            cyc++;
        end
        flush = 1'b1; in_data = 128'hdeadbeef_cafef00d_01234567_89abcdef; in_tag = 4'hF;
        #1;
        chk("flush_ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0; #1;
        chk("flush_occ", occupancy, 0);
        chk("flush_valid", out_valid, 0);

        // Reset mid-stream with one buffered state
        in_valid = 1'b1; in_data = rnd128(); in_tag = 4'h7;
        tick();
        in_valid = 1'b0; #1;
        chk("mid_occ", occupancy, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 128'h0);
        chk("mid_rst_tag", out_tag, 0);
        rst = 1'b0; #1;
        chk("mid_ready_after_rst", in_ready, 1);
        tick();

        // Throughput: 100 states with downstream always ready
        out_ready = 1'b1; in_valid = 1'b1; in_data = rnd128(); in_tag = 4'd0;
        base = n_out; sent = 0; cyc = 0;
        while (n_out - base < 100 && cyc < 300) begin
            tick();
            cyc++;
            if (last_acc) begin
                sent++;
                if (sent < 100) begin
                    in_data = rnd128(); in_tag = TAG_W'($urandom);
                end else in_valid = 1'b0;
            end
        end
        chk("thru_cycles", cyc, 101);
        chk("thru_count", n_out - base, 100);

        // Random traffic with occasional flushes
        repeat (300) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = rnd128();
            in_tag    = TAG_W'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 19) == 0);
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cyc = 0;
        while (qd.size() != 0 && cyc < 10) begin
            tick();
            cyc++;
        end
        chk("drain_empty", qd.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_inv_shift_rows_stage.md
AES_INV_SHIFT_ROWS_STAGE -- requirements
Module: aes_inv_shift_rows_stage

Interface
REQ-001 SHALL have parameter TAG_W, default 4: width of the sideband tag carried alongside each state.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port flush, input, 1: synchronous drop of all buffered states.
REQ-005 SHALL have port in_valid, input, 1: upstream state present.
REQ-006 SHALL have port in_ready, output, 1: stage accepts a state this cycle.
REQ-007 SHALL have port in_data, input, 128: AES state, byte i at bits [127-8i -: 8], column-major (i = 4c + r).
REQ-008 SHALL have port in_tag, input, TAG_W: sideband, passed through unmodified.
REQ-009 SHALL have port out_valid, output, 1: state available to the downstream InvSubBytes stage.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts.
REQ-011 SHALL have port out_data, output, 128: InvShiftRows result.
REQ-012 SHALL have port out_tag, output, TAG_W: tag belonging to out_data.
REQ-013 SHALL have port occupancy, output, 2: number of buffered states (0..2).

Function
REQ-014 SHALL compute output byte (r,c) = input byte (r, (c - r) mod 4), i.e. row r rotated right by r; row 0 unchanged.
REQ-015 SHALL transform at input capture; buffers hold transformed data; out_data/out_tag SHALL always be registered values.
REQ-016 SHALL complete an input handshake when in_valid and in_ready are both 1, and an output handshake when out_valid and out_ready are both 1.
REQ-017 SHALL assert out_valid in the cycle after the first accepted input (latency 1) and keep it asserted while occupancy > 0.
REQ-018 SHALL hold out_data/out_tag stable while out_valid=1 and out_ready=0.
REQ-019 SHALL deliver states in acceptance order; no loss, no duplication.
REQ-020 SHALL leave occupancy unchanged on a simultaneous input and output handshake.
REQ-021 SHALL not depend on in_valid to drive in_ready (no combinational in-to-ready path).
REQ-022 SHALL, on flush=1, set occupancy to 0 and out_valid to 0 next cycle; in_ready SHALL be 0 during flush; flush SHALL take priority over every handshake in the same cycle.
REQ-023 SHALL treat an X-free in_data as its only data requirement; in_data and in_tag are ignored when in_valid=0.

Reset
REQ-024 SHALL, while rst=1 at a clock edge, set out_valid=0, occupancy=0, out_data=0, out_tag=0; in_ready SHALL be 0 while rst=1.
REQ-025 SHALL discard any buffered state when rst is asserted mid-stream; rst SHALL take priority over flush.
REQ-026 SHALL assert in_ready in the first cycle after rst deasserts.

Configuration
REQ-027 SHALL, with AES_INV_SR_SKID_EN defined, implement a 2-entry skid buffer: in_ready = (occupancy < 2), registered and independent of out_ready; sustains 1 state/cycle.
REQ-028 SHALL, without AES_INV_SR_SKID_EN, implement a single register: in_ready = (occupancy == 0) | out_ready (combinational from out_ready); occupancy never exceeds 1; sustains 1 state/cycle.

Verification
REQ-029 SHALL pass the FIPS-197 vector: accept in_data=7ad5fda789ef4e272bca100b3d9ff59f, tag 3 -> next cycle out_valid=1, out_data=7a9f102789d5f50b2beffd9f3dca4ea7, out_tag=3.
REQ-030 SHALL pass the identity check: in_data=000102030405060708090a0b0c0d0e0f -> out_data=000d0a0704010e0b0805020f0c090603.
REQ-031 SHALL pass the back-pressure test: 8 back-to-back inputs with out_ready=0 for 5 cycles (skid build) -> in_ready drops at occupancy=2; on release all 8 emerge in order and tags match.
REQ-032 SHALL pass the flush test: occupancy=2, then flush for 1 cycle with in_valid=1 -> next cycle occupancy=0, out_valid=0, the flushed and same-cycle inputs never appear.
REQ-033 SHALL pass the reset test: rst mid-stream with occupancy=1 -> out_valid=0, out_data=0 next cycle; in_ready=1 the cycle after rst falls.
REQ-034 SHALL pass the throughput test: 100 random states with out_ready=1 -> 100 outputs in 101 cycles, each matching the reference InvShiftRows model, in both macro configurations.
